mul_seq_ctrl: RTL and testbench

- Iterative shift-add multiplier sequencer for the execute stage; implements MIPS MULT/MULTU into HI/LO.
- Owns one WIDTH-bit adder and sequences it over WIDTH cycles instead of instantiating a combinational array multiplier.
- Sits beside the ALU. The hazard unit stalls dependent MFHI/MFLO while busy is high.

---
 rtl/mul_seq_ctrl.sv | 99 +++++++++
 tb/tb_mul_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add MULT/MULTU sequencer: one WIDTH+1-bit adder reused over WIDTH cycles,
// magnitudes multiplied unsigned and the sign applied once at the end.
module mul_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state  | meaning
   // S_IDLE | waiting for start; hi/lo hold the last result
   // S_RUN  | one shift-add iteration per cycle, WIDTH iterations total
   // S_FIX  | apply sign to the magnitude product, load hi/lo, pulse done
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state_q;
   logic [WIDTH-1:0]   mcand_q;
   logic               neg_q;
   logic [WIDTH:0]     acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;
   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic [WIDTH-1:0]   mag_a_d;
   logic [WIDTH-1:0]   mag_b_d;
   logic [WIDTH:0]     sum_d;
   logic [2*WIDTH-1:0] prod_raw_d;
   logic [2*WIDTH-1:0] prod_d;

   // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
   always_comb begin
      mag_a_d    = (sign && a[WIDTH-1]) ? -a : a;
      mag_b_d    = (sign && b[WIDTH-1]) ? -b : b;
      sum_d      = acc_hi_q + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
      prod_raw_d = {acc_hi_q[WIDTH-1:0], acc_lo_q};
      prod_d     = neg_q ? -prod_raw_d : prod_raw_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mcand_q  <= mag_a_d;
                  neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_hi_q <= '0;
                  acc_lo_q <= mag_b_d;
                  count_q  <= '0;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               acc_hi_q <= {1'b0, sum_d[WIDTH:1]};
               acc_lo_q <= {sum_d[0], acc_lo_q[WIDTH-1:1]};
               count_q  <= count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               hi_q    <= prod_d[2*WIDTH-1:WIDTH];
               lo_q    <= prod_d[WIDTH-1:0];
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: hand-computed products, latency, reset and start-handling corners.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sign;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   mul_seq_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sign  (sign),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Full operation: present operands, count busy cycles, check result and that it holds.
   task automatic do_op(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el);
      int n;
      @(negedge clk);
      start = 1'b1; sign = s; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0; sign = ~s; a = $urandom; b = $urandom;
      check_val({tag, "_busy0"}, 64'(busy), 64'd1);
      n = 1;
      while (busy && n < 60) begin
         @(posedge clk); #1;
         if (busy) n++;
         if (n == 16) begin
            check_val({tag, "_hold_hi"}, 64'(hi), 64'(prev_hi));
            check_val({tag, "_hold_lo"}, 64'(lo), 64'(prev_lo));
         end
      end
      check_val({tag, "_busy_len"}, 64'(n), 64'd33);
      check_val({tag, "_done"}, 64'(done), 64'd1);
      check_val({tag, "_hi"}, 64'(hi), 64'(eh));
      check_val({tag, "_lo"}, 64'(lo), 64'(el));
      @(posedge clk); #1;
      check_val({tag, "_done_off"}, 64'(done), 64'd0);
      check_val({tag, "_hi_held"}, 64'(hi), 64'(eh));
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      int ndone;
      int first_k;
      logic [31:0] cap_hi;
      logic [31:0] cap_lo;
      logic        hi_nz;

      rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
      #12;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      do_op("u_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("s_mix",   1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("u_mix",   1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB);
      do_op("s_min2",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      do_op("s_min1",  1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
      do_op("s_zero",  1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
      do_op("s_small", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000A);

      // Reset mid-run, with a nonzero result already in hi/lo
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd7; b = 32'd9;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_val("mrst_busy", 64'(busy), 64'd0);
      check_val("mrst_done", 64'(done), 64'd0);
      check_val("mrst_hilo", {hi, lo}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check_val("mrst_no_done", 64'(ndone), 64'd0);
      prev_hi = '0; prev_lo = '0;

      // Start while busy must be ignored
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd3; b = 32'd4;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; first_k = 0; cap_hi = '1; cap_lo = '1;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         if (k == 5) begin start = 1'b1; a = 32'd100; b = 32'd100; end
         if (k == 6) start = 1'b0;
         if (done) begin
            ndone++;
            if (first_k == 0) begin first_k = k; cap_hi = hi; cap_lo = lo; end
         end
      end
      check_val("ign_ndone", 64'(ndone), 64'd1);
      check_val("ign_lat", 64'(first_k), 64'd33);
      check_val("ign_hi", 64'(cap_hi), 64'd0);
      check_val("ign_lo", 64'(cap_lo), 64'd12);

      // Back-to-back: start held high, second operands shown on the done cycle
      @(negedge clk);
      start = 1'b1; sign = 1'b0; a = 32'd2; b = 32'd5;
      @(posedge clk); #1;
      first_k = 0; hi_nz = 1'b0;
      for (int k = 1; k <= 60 && first_k == 0; k++) begin
         @(posedge clk); #1;
         if (hi != 32'd0) hi_nz = 1'b1;
         if (done) first_k = k;
      end
      check_val("b2b_lat1", 64'(first_k), 64'd33);
      check_val("b2b_lo1", 64'(lo), 64'd10);
      a = 32'd6; b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("b2b_accept", 64'(busy), 64'd1);
      first_k = 0;
      for (int k = 2; k <= 60 && first_k == 0; k++) begin
         @(posedge clk); #1;
         if (hi != 32'd0) hi_nz = 1'b1;
         if (done) first_k = k;
      end
      check_val("b2b_gap", 64'(first_k), 64'd34);
      check_val("b2b_lo2", 64'(lo), 64'd36);
      check_val("b2b_hi0", 64'(hi_nz), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
